// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef struct packed {
        logic       ext;
        logic       brk;
        logic [7:0] code;
    } ps2_evt_t;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    // Odd parity holds when data bits and parity bit together have an odd count of ones.
    function automatic logic odd_parity_ok(input logic [7:0] data, input logic par);
        return ^{data, par};
    endfunction

endpackage

// File: rtl/ps2_event_fifo.sv
// First-word fall-through FIFO of decoded key events.
module ps2_event_fifo
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          push,
    input  ps2_evt_t                      push_data,
    input  logic                          pop,
    output ps2_evt_t                      head,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          full,
    output logic                          empty
);

    localparam int AW = $clog2(FIFO_DEPTH);

    ps2_evt_t        mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [AW:0]     count_q, count_d;
    logic            wr_en;
    logic            rd_en;

    assign full  = (count_q == (AW+1)'(FIFO_DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

    // A push while full is only accepted when the head leaves in the same cycle.
    always_comb begin
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (wr_en && !rd_en) begin
            count_d = count_q + 1'b1;
        end else if (rd_en && !wr_en) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/ps2_key_receiver.sv
// PS/2 keyboard receiver: synchronise and filter the bus, frame bytes,
// fold E0/F0 prefixes into key events and queue them for the consumer.
module ps2_key_receiver
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 200000,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          kclk,
    input  logic                          kdata,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [7:0]                    evt_code,
    output logic                          evt_ext,
    output logic                          evt_brk,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          err_parity,
    output logic                          err_frame,
    output logic                          overflow
);

    localparam int FW = $clog2(FILTER_LEN);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    // Index 0 carries kclk, index 1 carries kdata.
    logic [1:0]    sync1_q, sync2_q;
    logic [1:0]    filt_q, filt_d;
    logic [FW-1:0] filt_cnt_q [2];
    logic [FW-1:0] filt_cnt_d [2];
    logic          kclk_prev_q;
    logic          fall_q, fall_d;
    logic          kdata_f;

    state_t        state_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          parity_ok_q;
    logic [TW-1:0] tmo_cnt_q;
    logic          err_frame_q;
    logic          err_parity_q;

    logic          timeout_hit;
    logic          start_bad;
    logic          stop_seen;
    logic          stop_bad;
    logic          par_bad;
    logic          byte_ok;
    logic          frame_err;

    logic          ext_q, ext_d;
    logic          brk_q, brk_d;
    logic          push;
    logic          pop;
    logic          overflow_q, overflow_d;
    ps2_evt_t      push_evt;
    ps2_evt_t      head_evt;
    logic          fifo_full;
    logic          fifo_empty;

    assign kdata_f = filt_q[1];

    // A line only follows the synchronised input after FILTER_LEN disagreeing samples in a row.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            filt_d[i]     = filt_q[i];
            filt_cnt_d[i] = '0;
            if (sync2_q[i] != filt_q[i]) begin
                if (filt_cnt_q[i] == FW'(FILTER_LEN - 1)) begin
                    filt_d[i] = sync2_q[i];
                end else begin
                    filt_cnt_d[i] = filt_cnt_q[i] + 1'b1;
                end
            end
        end
        fall_d = kclk_prev_q && !filt_q[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q       <= 2'b11;
            sync2_q       <= 2'b11;
            filt_q        <= 2'b11;
            filt_cnt_q[0] <= '0;
            filt_cnt_q[1] <= '0;
            kclk_prev_q   <= 1'b1;
            fall_q        <= 1'b0;
        end else begin
            sync1_q       <= {kdata, kclk};
            sync2_q       <= sync1_q;
            filt_q        <= filt_d;
            filt_cnt_q[0] <= filt_cnt_d[0];
            filt_cnt_q[1] <= filt_cnt_d[1];
            kclk_prev_q   <= filt_q[0];
            fall_q        <= fall_d;
        end
    end

    always_comb begin
        timeout_hit = (state_q != IDLE) && !fall_q && (tmo_cnt_q == TW'(TIMEOUT_CYC - 1));
        start_bad   = (state_q == IDLE) && fall_q && kdata_f;
        stop_seen   = (state_q == STOP) && fall_q;
        stop_bad    = stop_seen && !kdata_f;
        par_bad     = stop_seen && kdata_f && !parity_ok_q;
        byte_ok     = stop_seen && kdata_f && parity_ok_q;
        frame_err   = start_bad || stop_bad || timeout_hit;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_ok_q  <= 1'b0;
            tmo_cnt_q    <= '0;
            err_frame_q  <= 1'b0;
            err_parity_q <= 1'b0;
        end else begin
            err_frame_q  <= frame_err;
            err_parity_q <= par_bad;
            if (state_q == IDLE || fall_q) begin
                tmo_cnt_q <= '0;
            end else begin
                tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            if (timeout_hit) begin
                state_q <= IDLE;
            end else if (fall_q) begin
                case (state_q)
                    IDLE: begin
                        if (!kdata_f) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q   <= {kdata_f, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARITY;
                        end
                    end
                    PARITY: begin
                        parity_ok_q <= odd_parity_ok(shift_q, kdata_f);
                        state_q     <= STOP;
                    end
                    STOP: begin
                        state_q <= IDLE;
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    // Prefix bytes only arm the flags; the next real code consumes them, any error drops them.
    always_comb begin
        ext_d         = ext_q;
        brk_d         = brk_q;
        push          = 1'b0;
        push_evt.ext  = ext_q;
        push_evt.brk  = brk_q;
        push_evt.code = shift_q;
        if (frame_err || par_bad) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
        end else if (byte_ok) begin
            if (shift_q == PS2_EXT) begin
                ext_d = 1'b1;
            end else if (shift_q == PS2_BRK) begin
                brk_d = 1'b1;
            end else begin
                push  = 1'b1;
                ext_d = 1'b0;
                brk_d = 1'b0;
            end
        end
        pop        = !fifo_empty && evt_ready;
        overflow_d = push && fifo_full && !pop;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ext_q      <= 1'b0;
            brk_q      <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            ext_q      <= ext_d;
            brk_q      <= brk_d;
            overflow_q <= overflow_d;
        end
    end

    ps2_event_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_evt),
        .pop       (pop),
        .head      (head_evt),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign evt_valid  = !fifo_empty;
    assign evt_code   = fifo_empty ? 8'h00 : head_evt.code;
    assign evt_ext    = !fifo_empty && head_evt.ext;
    assign evt_brk    = !fifo_empty && head_evt.brk;
    assign err_parity = err_parity_q;
    assign err_frame  = err_frame_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_ps2_key_receiver.sv
// Self-checking bench: PS/2 frames driven bit by bit, compared against a queue-based event model.
module tb_ps2_key_receiver;

    localparam int FL   = 8;
    localparam int TC   = 1000;
    localparam int FD   = 4;
    localparam int HALF = 12;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     kclk;
    logic                     kdata;
    logic                     evt_valid;
    logic                     evt_ready;
    logic [7:0]               evt_code;
    logic                     evt_ext;
    logic                     evt_brk;
    logic [$clog2(FD):0]      fifo_count;
    logic                     err_parity;
    logic                     err_frame;
    logic                     overflow;

    int n_checks = 0;
    int n_errors = 0;
    int cnt_fe = 0, cnt_pe = 0, cnt_ov = 0;
    int exp_fe = 0, exp_pe = 0, exp_ov = 0;
    logic [9:0] model [$];
    logic m_ext = 1'b0;
    logic m_brk = 1'b0;

    ps2_key_receiver #(
        .FILTER_LEN  (FL),
        .TIMEOUT_CYC (TC),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .kclk       (kclk),
        .kdata      (kdata),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_ext    (evt_ext),
        .evt_brk    (evt_brk),
        .fifo_count (fifo_count),
        .err_parity (err_parity),
        .err_frame  (err_frame),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (err_frame)  cnt_fe++;
        if (err_parity) cnt_pe++;
        if (overflow)   cnt_ov++;
    end

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Sends the first nbits of a frame: start, 8 data LSB first, odd parity (optionally flipped), stop.
    task automatic applyStimulus(input logic [7:0] d, input bit par_flip, input bit stop_v, input int nbits);
        logic [10:0] bits;
        bits = {stop_v, (~^d) ^ par_flip, d, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            kdata = bits[i];
            waitCycles(HALF);
            kclk = 1'b0;
            waitCycles(HALF);
            kclk = 1'b1;
        end
        kdata = 1'b1;
        waitCycles(2 * HALF);
    endtask

    task automatic modelFrame(input logic [7:0] d, input bit par_flip, input bit stop_v);
        if (!stop_v) begin
            exp_fe++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (par_flip) begin
            exp_pe++;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end else if (d == 8'hE0) begin
            m_ext = 1'b1;
        end else if (d == 8'hF0) begin
            m_brk = 1'b1;
        end else begin
            if (model.size() == FD) exp_ov++;
            else model.push_back({m_ext, m_brk, d});
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic checkCounters(input string tag);
        checkOutput({tag, "_err_frame"},  cnt_fe, exp_fe);
        checkOutput({tag, "_err_parity"}, cnt_pe, exp_pe);
        checkOutput({tag, "_overflow"},   cnt_ov, exp_ov);
        checkOutput({tag, "_count"},      32'(fifo_count), model.size());
    endtask

    task automatic sendAndCheck(input logic [7:0] d, input bit par_flip, input bit stop_v, input string tag);
        applyStimulus(d, par_flip, stop_v, 11);
        modelFrame(d, par_flip, stop_v);
        checkCounters(tag);
    endtask

    // Pops with a random ready pattern, checking the head against the model every cycle it is valid.
    task automatic drain(input string tag);
        int budget;
        budget = 2000;
        while (model.size() > 0 && budget > 0) begin
            @(negedge clk);
            budget--;
            evt_ready = 1'b0;
            if (evt_valid) begin
                checkOutput({tag, "_head"}, {evt_ext, evt_brk, evt_code}, model[0]);
                if ($urandom % 2 == 0) begin
                    evt_ready = 1'b1;
                    void'(model.pop_front());
                end
            end
        end
        @(negedge clk);
        evt_ready = 1'b0;
        if (budget == 0) checkOutput({tag, "_drain_timeout"}, 1, 0);
        @(negedge clk);
        checkOutput({tag, "_empty"}, {evt_valid, 31'(fifo_count)}, 0);
    endtask

    task automatic applyReset();
        rst = 1'b1;
        waitCycles(3);
        checkOutput("reset_outputs",
            {evt_valid, evt_code, evt_ext, evt_brk, fifo_count, err_parity, err_frame, overflow}, 0);
        model.delete();
        m_ext = 1'b0;
        m_brk = 1'b0;
        rst = 1'b0;
        waitCycles(5);
    endtask

    initial begin
        int n;
        logic [7:0] d;
        bit flip, stop_v;
        int len;

        rst       = 1'b1;
        kclk      = 1'b1;
        kdata     = 1'b1;
        evt_ready = 1'b0;
        @(negedge clk);
        applyReset();

        // Single make with event latency measured from the raw stop-bit falling edge.
        applyStimulus(8'h1C, 1'b0, 1'b1, 10);
        kdata = 1'b1;
        waitCycles(HALF);
        kclk = 1'b0;
        n = 0;
        while (!evt_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("evt_latency", n, FL + 4);
        waitCycles(HALF);
        kclk = 1'b1;
        waitCycles(2 * HALF);
        modelFrame(8'h1C, 1'b0, 1'b1);
        checkCounters("make");
        checkOutput("make_head", {evt_ext, evt_brk, evt_code}, {2'b00, 8'h1C});
        drain("make");

        // Prefixed sequences.
        sendAndCheck(8'hF0, 1'b0, 1'b1, "brk_pre");
        sendAndCheck(8'h1C, 1'b0, 1'b1, "brk_code");
        sendAndCheck(8'hE0, 1'b0, 1'b1, "ext_pre");
        sendAndCheck(8'hF0, 1'b0, 1'b1, "ext_brk_pre");
        sendAndCheck(8'h75, 1'b0, 1'b1, "ext_brk_code");
        drain("prefix");

        // Bad parity, then a good frame.
        sendAndCheck(8'h1C, 1'b1, 1'b1, "bad_par");
        sendAndCheck(8'h1C, 1'b0, 1'b1, "after_par");
        drain("parity");

        // Timeout on a partial frame, then a normal frame.
        applyStimulus(8'h00, 1'b0, 1'b1, 5);
        waitCycles(TC + 100);
        exp_fe++;
        checkCounters("timeout");
        sendAndCheck(8'h29, 1'b0, 1'b1, "after_tmo");
        drain("timeout");

        // A bad stop bit after E0 must drop the pending prefix.
        sendAndCheck(8'hE0, 1'b0, 1'b1, "stop_pre");
        sendAndCheck(8'h33, 1'b0, 1'b0, "bad_stop");
        sendAndCheck(8'h75, 1'b0, 1'b1, "after_stop");
        drain("stop");

        // Overflow with the consumer stalled.
        for (int i = 1; i <= FD + 1; i++) begin
            sendAndCheck(8'(i), 1'b0, 1'b1, "ovf_fill");
        end
        checkOutput("ovf_head", {evt_ext, evt_brk, evt_code}, {2'b00, 8'h01});
        drain("overflow");

        // Short glitches on an idle bus: a false kclk fall with data high would raise err_frame.
        kclk = 1'b0;
        waitCycles(3);
        kclk = 1'b1;
        waitCycles(30);
        kdata = 1'b0;
        waitCycles(FL - 1);
        kdata = 1'b1;
        waitCycles(30);
        checkCounters("glitch");

        // Reset mid-frame with an event queued.
        sendAndCheck(8'h16, 1'b0, 1'b1, "pre_rst");
        applyStimulus(8'hAA, 1'b0, 1'b1, 6);
        applyReset();
        waitCycles(TC + 50);
        checkCounters("post_rst");
        sendAndCheck(8'h29, 1'b0, 1'b1, "rst_next");
        drain("reset");

        // Randomised bursts of frames, each followed by a randomised drain.
        for (int b = 0; b < 6; b++) begin
            len = $urandom_range(1, FD + 2);
            for (int f = 0; f < len; f++) begin
                case ($urandom % 8)
                    0:       d = 8'hE0;
                    1:       d = 8'hF0;
                    default: d = 8'($urandom);
                endcase
                flip   = ($urandom % 8 == 0);
                stop_v = ($urandom % 8 != 0);
                sendAndCheck(d, flip, stop_v, "rand");
            end
            drain("rand");
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
